charge_meas_avg: RTL

- Measurement front stage directly upstream of the secant current controller.
- Watches the controller's i_ref and waits a fixed settling window after every i_ref change.
- Then averages 2**LOG2_AVG valid ADC charge samples and presents the result as q_measured with a one-cycle ready pulse.
- Guarantees the controller only ever sees charge values measured under the current i_ref.

---
 rtl/charge_meas_avg.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/charge_meas_avg.sv
// charge_meas_avg: waits out a settling window after each i_ref change, then averages 2**LOG2_AVG ADC samples.
// Optional: define CHARGE_MEAS_SAT_FLAG_EN to add the per-measurement 'saturated' output.
`default_nettype none

module charge_meas_avg #(
    parameter int BUS_WIDTH     = 10,
    parameter int LOG2_AVG      = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic [BUS_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy
`ifdef CHARGE_MEAS_SAT_FLAG_EN
    ,
    output logic                 saturated
`endif
);

    localparam int ACC_W = BUS_WIDTH + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_AVG) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BUS_WIDTH-1:0] i_ref_q;
    logic [SET_W-1:0]     settle_cnt;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     sample_cnt;

    logic                 iref_change;
    logic [ACC_W-1:0]     acc_sum;
    logic                 load_settle;
    logic                 dec_settle;
    logic                 clear_acc;
    logic                 take_sample;
    logic                 finish;

    assign iref_change = (i_ref != i_ref_q);
    assign acc_sum     = acc + ACC_W'(adc_data);
    assign busy        = (state == SETTLE) || (state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An i_ref change outranks a completing sample so a result never mixes two references.
    always_comb begin
        state_nxt   = state;
        load_settle = 1'b0;
        dec_settle  = 1'b0;
        clear_acc   = 1'b0;
        take_sample = 1'b0;
        finish      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            clear_acc = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt   = SETTLE;
                    load_settle = 1'b1;
                end
                SETTLE: begin
                    if (iref_change) begin
                        load_settle = 1'b1;
                    end else if (settle_cnt == '0) begin
                        state_nxt = ACCUM;
                        clear_acc = 1'b1;
                    end else begin
                        dec_settle = 1'b1;
                    end
                end
                ACCUM: begin
                    if (iref_change) begin
                        state_nxt   = SETTLE;
                        load_settle = 1'b1;
                        clear_acc   = 1'b1;
                    end else if (adc_valid) begin
                        take_sample = 1'b1;
                        if (sample_cnt == LAST_SAMPLE) begin
                            state_nxt = DONE;
                            finish    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nxt   = SETTLE;
                    load_settle = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Result and ready are registered on the final sample so both appear together in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ref_q    <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            sample_cnt <= '0;
            q_measured <= '0;
            ready      <= 1'b0;
        end else begin
            i_ref_q <= i_ref;
            ready   <= finish;
            if (load_settle) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (dec_settle) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end
            if (clear_acc) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (take_sample) begin
                acc        <= acc_sum;
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (finish) begin
                q_measured <= acc_sum[ACC_W-1:LOG2_AVG];
            end
        end
    end

`ifdef CHARGE_MEAS_SAT_FLAG_EN
    logic sat_sticky;
    logic sample_sat;

    assign sample_sat = (adc_data == '0) || (adc_data == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky <= 1'b0;
            saturated  <= 1'b0;
        end else begin
            if (clear_acc) begin
                sat_sticky <= 1'b0;
            end else if (take_sample) begin
                sat_sticky <= sat_sticky | sample_sat;
            end
            if (finish) begin
                saturated <= sat_sticky | sample_sat;
            end
        end
    end
`endif

endmodule

`default_nettype wire
